// File: rtl/sg_config_sequencer_pkg.sv
// Shared definitions for the signal_generator configuration sequencer:
// FSM encodings, register word offsets, CTRL/STAT bit positions and small helpers.
package sg_config_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_TAIL    = 3'd3,
        ST_RESUME  = 3'd4
    } seq_state_e;

    // Word offsets inside the 32-byte window (byte address bits [4:2]).
    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_FSEL = 3'd1;
    localparam logic [2:0] REG_STAT = 3'd2;

    localparam int CTRL_START     = 0;
    localparam int CTRL_EN        = 1;
    localparam int CTRL_RESUME    = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_OVR       = 2;
    localparam int STAT_STATE_LSB = 4;

    // Width able to hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/sg_config_sequencer_bit_timer.sv
// sg_bit_timer: loadable down-counter; tc_o is high while the count sits at zero,
// so loading N-1 on a state entry makes tc_o mark the last of N cycles.
module sg_bit_timer
    import sg_config_sequencer_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sg_config_sequencer.sv
// Wishbone-programmable sequencer: quiesces the CCD signal_generator, shifts a
// frequency-select word out MSB-first under load_config, then restores enable.
module sg_config_sequencer
    import sg_config_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0020,
    parameter int          FSEL_W        = 4,
    parameter int          BIT_CYCLES    = 4,
    parameter int          SETTLE_CYCLES = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        o_enable,
    output logic        o_f_select_serial,
    output logic        o_load_config,
    output logic        o_irq
);

    localparam int CNT_W = cnt_width((BIT_CYCLES > SETTLE_CYCLES) ? BIT_CYCLES : SETTLE_CYCLES);
    localparam int IDX_W = cnt_width(FSEL_W);
    localparam logic [CNT_W-1:0] BIT_LOAD    = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FSEL_W - 1);

    // Bus handshake: an access is taken on the first cycle stb&cyc hits the
    // window, ack follows one cycle later and is never asserted twice in a row.
    logic        hit, acc, wr, rd, wr_b0;
    logic [2:0]  word_off;
    logic        ctrl_wr, fsel_wr, stat_wr, start_req, busy;
    logic [31:0] be_mask;
    logic [31:0] rdata;

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              ctrl_en_q, ctrl_resume_q;
    logic [FSEL_W-1:0] fsel_q, fsel_d;
    logic              ovr_q, done_q;

    seq_state_e        state_q;
    logic              enable_q, load_q, serial_q, irq_q;
    logic [IDX_W-1:0]  idx_q, next_idx, next_pos;
    logic [FSEL_W-1:0] shadow_q;

    logic              tmr_load, tmr_tc;
    logic [CNT_W-1:0]  tmr_val;
    logic              unused_bits;

    assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign acc       = hit & ~ack_q;
    assign wr        = acc & wbs_we_i;
    assign rd        = acc & ~wbs_we_i;
    assign wr_b0     = wr & wbs_sel_i[0];
    assign word_off  = wbs_adr_i[4:2];
    assign ctrl_wr   = wr_b0 & (word_off == REG_CTRL);
    assign fsel_wr   = wr & (word_off == REG_FSEL);
    assign stat_wr   = wr_b0 & (word_off == REG_STAT);
    assign start_req = ctrl_wr & wbs_dat_i[CTRL_START];
    assign busy      = (state_q != ST_IDLE);
    assign be_mask   = byte_mask(wbs_sel_i);
    assign fsel_d    = (fsel_q & ~be_mask[FSEL_W-1:0]) | (wbs_dat_i[FSEL_W-1:0] & be_mask[FSEL_W-1:0]);
    assign next_idx  = idx_q + 1'b1;
    assign next_pos  = IDX_LAST - next_idx;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:FSEL_W], be_mask[31:FSEL_W]};

    always_comb begin
        rdata = '0;
        case (word_off)
            REG_CTRL: begin
                rdata[CTRL_EN]     = ctrl_en_q;
                rdata[CTRL_RESUME] = ctrl_resume_q;
            end
            REG_FSEL: rdata[FSEL_W-1:0] = fsel_q;
            REG_STAT: begin
                rdata[STAT_BUSY]             = busy;
                rdata[STAT_DONE]             = done_q;
                rdata[STAT_OVR]              = ovr_q;
                rdata[STAT_STATE_LSB +: 3]   = state_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q         <= 1'b0;
            dat_q         <= '0;
            ctrl_en_q     <= 1'b0;
            ctrl_resume_q <= 1'b0;
            fsel_q        <= '0;
            ovr_q         <= 1'b0;
        end else begin
            ack_q <= acc;
            dat_q <= rd ? rdata : '0;
            if (ctrl_wr) begin
                ctrl_en_q     <= wbs_dat_i[CTRL_EN];
                ctrl_resume_q <= wbs_dat_i[CTRL_RESUME];
            end
            if (fsel_wr) begin
                fsel_q <= fsel_d;
            end
            if (start_req && busy) begin
                ovr_q <= 1'b1;
            end else if (stat_wr && wbs_dat_i[STAT_OVR]) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // Timer is reloaded on every state entry that needs timing.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = BIT_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    tmr_load = 1'b1;
                    tmr_val  = enable_q ? SETTLE_LOAD : BIT_LOAD;
                end
            end
            ST_QUIESCE, ST_LOAD, ST_TAIL: tmr_load = tmr_tc;
            default: ;
        endcase
    end

    sg_bit_timer #(.W(CNT_W)) u_timer (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            load_q   <= 1'b0;
            serial_q <= 1'b0;
            irq_q    <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (stat_wr && wbs_dat_i[STAT_DONE]) begin
                done_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    load_q   <= 1'b0;
                    serial_q <= 1'b0;
                    idx_q    <= '0;
                    if (ctrl_wr) begin
                        enable_q <= wbs_dat_i[CTRL_EN];
                    end
                    if (start_req) begin
                        shadow_q <= fsel_q;
                        enable_q <= 1'b0;
                        if (enable_q) begin
                            state_q <= ST_QUIESCE;
                        end else begin
                            state_q  <= ST_LOAD;
                            load_q   <= 1'b1;
                            serial_q <= fsel_q[FSEL_W-1];
                        end
                    end
                end
                ST_QUIESCE: begin
                    if (tmr_tc) begin
                        state_q  <= ST_LOAD;
                        load_q   <= 1'b1;
                        serial_q <= shadow_q[FSEL_W-1];
                    end
                end
                ST_LOAD: begin
                    if (tmr_tc) begin
                        if (idx_q == IDX_LAST) begin
                            state_q  <= ST_TAIL;
                            load_q   <= 1'b0;
                            serial_q <= 1'b0;
                            idx_q    <= '0;
                        end else begin
                            idx_q    <= next_idx;
                            serial_q <= shadow_q[next_pos];
                        end
                    end
                end
                ST_TAIL: begin
                    // irq and the restored enable are visible during RESUME itself.
                    if (tmr_tc) begin
                        state_q  <= ST_RESUME;
                        irq_q    <= 1'b1;
                        enable_q <= ctrl_en_q & ctrl_resume_q;
                    end
                end
                ST_RESUME: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wbs_ack_o         = ack_q;
    assign wbs_dat_o         = dat_q;
    assign o_enable          = enable_q;
    assign o_f_select_serial = serial_q;
    assign o_load_config     = load_q;
    assign o_irq             = irq_q;

endmodule

// File: tb/tb_sg_config_sequencer.sv
// Directed bench for sg_config_sequencer: bus register access, sequence timing
// traces, overrun handling and asynchronous reset mid-load.
module tb_sg_config_sequencer;

    localparam logic [31:0] BASE  = 32'h3000_0020;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_FSEL = BASE + 32'h04;
    localparam logic [31:0] A_STAT = BASE + 32'h08;
    localparam int TR_LEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] wdat = '0, adr = '0;
    logic        ack;
    logic [31:0] rdat_o;
    logic        en_o, ser_o, load_o, irq_o;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0]  tr [TR_LEN];
    logic [31:0] rv;

    sg_config_sequencer dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst_n),
        .wbs_stb_i         (stb),
        .wbs_cyc_i         (cyc),
        .wbs_we_i          (we),
        .wbs_sel_i         (sel),
        .wbs_dat_i         (wdat),
        .wbs_adr_i         (adr),
        .wbs_ack_o         (ack),
        .wbs_dat_o         (rdat_o),
        .o_enable          (en_o),
        .o_f_select_serial (ser_o),
        .o_load_config     (load_o),
        .o_irq             (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] r);
        logic got;
        got = 1'b0;
        r   = '0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                r   = rdat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("wb_ack", {31'b0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] dummy;
        wb_cycle(a, 1'b1, d, s, dummy);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        wb_cycle(a, 1'b0, '0, 4'hF, r);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_read(a, r);
        chk(tag, r, exp);
    endtask

    // Caller sits at the negedge on which the start write saw ack: k=0 is that cycle.
    task automatic capture;
        for (int k = 0; k < TR_LEN; k++) begin
            tr[k] = {en_o, load_o, ser_o, irq_o};
            @(negedge clk);
        end
    endtask

    // Expected {enable, load, serial, irq} for cycle k after the start ack.
    function automatic logic [3:0] exp_out(input int k, input int q, input logic [3:0] f,
                                           input logic en_after);
        logic [3:0] sh;
        if (k < q) return 4'b0000;
        if (k < q + 16) begin
            sh = f >> (3 - (k - q) / 4);
            return {1'b0, 1'b1, sh[0], 1'b0};
        end
        if (k < q + 20) return 4'b0000;
        if (k == q + 20) return {en_after, 3'b001};
        return {en_after, 3'b000};
    endfunction

    task automatic check_trace(input string name, input int q, input logic [3:0] f,
                               input logic en_after);
        for (int k = 0; k < TR_LEN; k++) begin
            chk($sformatf("trace_%s_k%0d", name, k), {28'b0, tr[k]}, {28'b0, exp_out(k, q, f, en_after)});
        end
    endtask

    initial begin
        logic seen;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_outputs", {28'b0, en_o, load_o, ser_o, irq_o}, 32'h0);
        rst_n = 1'b1;
        read_chk("rst_stat", A_STAT, 32'h0);
        read_chk("rst_fsel", A_FSEL, 32'h0);
        read_chk("rst_ctrl", A_CTRL, 32'h0);

        // Window miss: no ack, no data
        seen = 1'b0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0040; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | ack | (|rdat_o);
        end
        stb = 1'b0; cyc = 1'b0;
        chk("miss_no_ack", {31'b0, seen}, 32'h0);

        // Unmapped offsets ack and read zero, writes dropped
        read_chk("unmapped_0c", BASE + 32'h0C, 32'h0);
        wb_write(BASE + 32'h10, 32'hFFFF_FFFF);
        read_chk("unmapped_10", BASE + 32'h10, 32'h0);

        // en=1, FSEL=1000, resume=0
        wb_write(A_FSEL, 32'h8);
        wb_write(A_CTRL, 32'h2);
        chk("en_applied_idle", {31'b0, en_o}, 32'h1);
        read_chk("ctrl_en", A_CTRL, 32'h2);
        wb_write(A_CTRL, 32'h3);
        capture();
        check_trace("seq_1000", 8, 4'b1000, 1'b0);
        read_chk("stat_done_1", A_STAT, 32'h2);
        read_chk("ctrl_start_selfclr", A_CTRL, 32'h2);

        // en=1, resume=1, FSEL=0110
        wb_write(A_FSEL, 32'h6);
        wb_write(A_CTRL, 32'h6);
        chk("en_reapplied", {31'b0, en_o}, 32'h1);
        wb_write(A_CTRL, 32'h7);
        capture();
        check_trace("seq_resume", 8, 4'b0110, 1'b1);

        // en=0: no quiesce, FSEL=1011
        wb_write(A_CTRL, 32'h0);
        chk("en_cleared", {31'b0, en_o}, 32'h0);
        wb_write(A_FSEL, 32'hB);
        wb_write(A_FSEL, 32'h4, 4'b0010);
        read_chk("fsel_bytesel", A_FSEL, 32'hB);
        wb_write(A_CTRL, 32'h1);
        capture();
        check_trace("seq_1011", 0, 4'b1011, 1'b0);
        read_chk("stat_done_2", A_STAT, 32'h2);
        wb_write(A_STAT, 32'h2);
        read_chk("stat_w1c_done", A_STAT, 32'h0);

        // Start and FSEL write while busy
        wb_write(A_CTRL, 32'h1);
        fork
            capture();
            begin
                repeat (3) @(negedge clk);
                wb_write(A_FSEL, 32'h1);
                wb_write(A_CTRL, 32'h1);
                read_chk("stat_busy_ovr", A_STAT, 32'h25);
            end
        join
        check_trace("seq_ovr", 0, 4'b1011, 1'b0);
        read_chk("fsel_updated", A_FSEL, 32'h1);
        read_chk("stat_ovr_done", A_STAT, 32'h6);
        wb_write(A_STAT, 32'h6);
        read_chk("stat_w1c_both", A_STAT, 32'h0);
        wb_write(A_CTRL, 32'h1);
        capture();
        check_trace("seq_0001", 0, 4'b0001, 1'b0);

        // Asynchronous reset in the middle of LOAD
        wb_write(A_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        chk("pre_rst_load", {31'b0, load_o}, 32'h1);
        #3 rst_n = 1'b0;
        #1 chk("async_rst_outputs", {28'b0, en_o, load_o, ser_o, irq_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen = seen | irq_o | load_o;
        end
        chk("post_rst_quiet", {31'b0, seen}, 32'h0);
        read_chk("post_rst_stat", A_STAT, 32'h0);
        read_chk("post_rst_ctrl", A_CTRL, 32'h0);
        read_chk("post_rst_fsel", A_FSEL, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
